// File: rtl/sdc_blk_rd_sink.sv
// sdc_blk_rd_sink: consumer of the single-block read deserializer.
// Buffers each 64-bit word in a one-deep holding register, writes it to the
// data BRAM at an incrementing address, then folds its 64 bits serially
// (MSB first) into a CRC-16-CCITT and finally compares the result against
// the CRC received from the card.
//
// Strobe semantics: every *_strb input is a single-cycle pulse with no
// back-pressure. A word that cannot be accepted (holding register full, or
// the block already has WORDS_PER_BLK words) is discarded and flagged in the
// sticky ovr_err.
module sdc_blk_rd_sink #(
    parameter int ADDR_W        = 6,
    parameter int WORDS_PER_BLK = 64,
    parameter int BASE_ADDR     = 0
) (
    input  logic              sdc_clk,
    input  logic              reset,
    input  logic              blk_start_strb,
    input  logic              wrd_rdy_strb,
    input  logic [63:0]       dat_wrd,
    input  logic              crc_rdy_strb,
    input  logic [15:0]       crc_16,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [63:0]       bram_din,
    output logic              busy,
    output logic              blk_done,
    output logic              crc_ok,
    output logic              crc_err,
    output logic              ovr_err,
    output logic [15:0]       crc_calc,
    output logic [2:0]        dbg_state
);

    localparam int WCNT_W = $clog2(WORDS_PER_BLK + 1);
    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(WORDS_PER_BLK);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_CALC  = 3'd3,
        S_WCRC  = 3'd4,
        S_CHECK = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [63:0]       hold_q, hold_d;
    logic              hold_v_q, hold_v_d;
    logic [63:0]       shift_q, shift_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       crc_q, crc_d;
    logic [15:0]       rx_crc_q, rx_crc_d;
    logic              rx_v_q, rx_v_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [63:0]       bram_din_q, bram_din_d;
    logic              busy_q, busy_d;
    logic              blk_done_q, blk_done_d;
    logic              crc_ok_q, crc_ok_d;
    logic              crc_err_q, crc_err_d;
    logic              ovr_err_q, ovr_err_d;

    // One serial CRC-16-CCITT step (poly 0x1021).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // State register.
    always_ff @(posedge sdc_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a block start aborts whatever is in flight.
    always_comb begin
        state_d = state_q;
        if (blk_start_strb) begin
            state_d = S_WAIT;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_WAIT:  if (hold_v_q) state_d = S_LOAD;
                S_LOAD:  state_d = S_CALC;
                S_CALC: begin
                    if (bit_cnt_q == 6'd63) begin
                        state_d = (wcnt_q < WCNT_FULL) ? S_WAIT : S_WCRC;
                    end
                end
                S_WCRC:  if (rx_v_q) state_d = S_CHECK;
                S_CHECK: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values, keyed off the current state.
    always_comb begin
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        shift_d     = shift_q;
        wcnt_d      = wcnt_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        rx_v_d      = rx_v_q;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        busy_d      = busy_q;
        blk_done_d  = 1'b0;
        crc_ok_d    = crc_ok_q;
        crc_err_d   = crc_err_q;
        ovr_err_d   = ovr_err_q;

        if (blk_start_strb) begin
            // Fresh block: drop all per-block state, including any word or
            // CRC strobed in the same cycle.
            hold_v_d  = 1'b0;
            wcnt_d    = '0;
            bit_cnt_d = '0;
            crc_d     = '0;
            rx_v_d    = 1'b0;
            crc_ok_d  = 1'b0;
            crc_err_d = 1'b0;
            ovr_err_d = 1'b0;
            busy_d    = 1'b1;
        end else if (state_q != S_IDLE) begin
            // Word intake: the holding register is one deep and never
            // overwritten; the block never takes more than WORDS_PER_BLK.
            if (wrd_rdy_strb) begin
                if (hold_v_q || (wcnt_q == WCNT_FULL)) begin
                    ovr_err_d = 1'b1;
                end else begin
                    hold_d   = dat_wrd;
                    hold_v_d = 1'b1;
                end
            end
            // The received CRC may arrive while the engine still lags.
            if (crc_rdy_strb) begin
                rx_crc_d = crc_16;
                rx_v_d   = 1'b1;
            end

            case (state_q)
                S_LOAD: begin
                    shift_d     = hold_q;
                    hold_v_d    = 1'b0;
                    bram_we_d   = 1'b1;
                    bram_addr_d = BASE_A + ADDR_W'(wcnt_q);
                    bram_din_d  = hold_q;
                    wcnt_d      = wcnt_q + 1'b1;
                    bit_cnt_d   = '0;
                end
                S_CALC: begin
                    crc_d     = crc_step(crc_q, shift_q[63]);
                    shift_d   = {shift_q[62:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                S_CHECK: begin
                    blk_done_d = 1'b1;
                    crc_ok_d   = (crc_q == rx_crc_q);
                    crc_err_d  = (crc_q != rx_crc_q);
                    busy_d     = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sdc_clk) begin
        if (reset) begin
            hold_q      <= '0;
            hold_v_q    <= 1'b0;
            shift_q     <= '0;
            wcnt_q      <= '0;
            bit_cnt_q   <= '0;
            crc_q       <= '0;
            rx_crc_q    <= '0;
            rx_v_q      <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            busy_q      <= 1'b0;
            blk_done_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            shift_q     <= shift_d;
            wcnt_q      <= wcnt_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            rx_v_q      <= rx_v_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            busy_q      <= busy_d;
            blk_done_q  <= blk_done_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign busy      = busy_q;
    assign blk_done  = blk_done_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign ovr_err   = ovr_err_q;
    assign crc_calc  = crc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sdc_blk_rd_sink.sv
// Directed bench for sdc_blk_rd_sink. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. BRAM writes are
// checked in order against an expected queue of {addr, din}.
module tb_sdc_blk_rd_sink;

  localparam int ADDR_W = 6;

  logic              sdc_clk = 1'b0;
  logic              reset = 1'b1;
  logic              blk_start_strb = 1'b0;
  logic              wrd_rdy_strb = 1'b0;
  logic [63:0]       dat_wrd = '0;
  logic              crc_rdy_strb = 1'b0;
  logic [15:0]       crc_16 = '0;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [63:0]       bram_din;
  logic              busy;
  logic              blk_done;
  logic              crc_ok;
  logic              crc_err;
  logic              ovr_err;
  logic [15:0]       crc_calc;
  logic [2:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [ADDR_W+63:0] exp_q[$];
  logic [ADDR_W+63:0] exp_w;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  sdc_blk_rd_sink #(.ADDR_W(ADDR_W), .WORDS_PER_BLK(64), .BASE_ADDR(0)) dut (
    .sdc_clk(sdc_clk), .reset(reset), .blk_start_strb(blk_start_strb),
    .wrd_rdy_strb(wrd_rdy_strb), .dat_wrd(dat_wrd), .crc_rdy_strb(crc_rdy_strb),
    .crc_16(crc_16), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .blk_done(blk_done), .crc_ok(crc_ok), .crc_err(crc_err),
    .ovr_err(ovr_err), .crc_calc(crc_calc), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sdc_clk = ~sdc_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard: BRAM write stream ----------------
  always @(negedge sdc_clk) begin
    if (!reset && bram_we) begin
      we_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL bram_wr_unexpected: addr=%0d din=%h, required no write", bram_addr, bram_din);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bram_addr, bram_din} !== exp_w) begin
          n_err++;
          $display("FAIL bram_wr: addr=%0d din=%h, required addr=%0d din=%h",
                   bram_addr, bram_din, exp_w[ADDR_W+63:64], exp_w[63:0]);
        end
      end
    end
    if (!reset && blk_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sdc_clk);
    #1;
  endtask

  task automatic pulse_start();
    blk_start_strb = 1'b1;
    tick();
    blk_start_strb = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    dat_wrd = w;
    wrd_rdy_strb = 1'b1;
    tick();
    wrd_rdy_strb = 1'b0;
  endtask

  task automatic send_crc(input logic [15:0] c);
    crc_16 = c;
    crc_rdy_strb = 1'b1;
    tick();
    crc_rdy_strb = 1'b0;
  endtask

  // Waits for blk_done; k is the cycle distance from the CRC strobe.
  task automatic wait_done(output bit got, output int k);
    got = 1'b0;
    k = 1;
    while (k < 300) begin
      @(negedge sdc_clk);
      if (blk_done) begin
        got = 1'b1;
        break;
      end
      k++;
    end
  endtask

  // Sends 64 copies of w spaced 66 cycles apart (expecting addr 0..63),
  // optionally an excess word 8 cycles after the last, and the CRC 16 cycles
  // after the last word. lat = cycles from first strobe to first bram_we.
  task automatic run_block(input logic [63:0] w, input logic [15:0] c, input bit extra,
                           output int lat, output bit got, output int done_k);
    logic [ADDR_W-1:0] a;
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      a = i[ADDR_W-1:0];
      exp_q.push_back({a, w});
      send_word(w);
      if (i == 0) begin
        lat = 1;
        while (lat < 10) begin
          @(negedge sdc_clk);
          if (bram_we) break;
          lat++;
        end
        repeat (66 - lat) tick();
      end else if (i < 63) begin
        repeat (65) tick();
      end
    end
    repeat (7) tick();
    if (extra) send_word(~w);
    else tick();
    repeat (7) tick();
    send_crc(c);
    wait_done(got, done_k);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge sdc_clk);
    n_vec++;
    if ({bram_we, busy, blk_done, crc_ok, crc_err, ovr_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 000000",
               {bram_we, busy, blk_done, crc_ok, crc_err, ovr_err});
    end
    n_vec++;
    if ({bram_addr, bram_din, crc_calc} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr=%0d din=%h crc=%h, required all 0", bram_addr, bram_din, crc_calc);
    end
    n_vec++;
    if (dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ignore_idle();
    int we0;
    we0 = we_cnt;
    send_word(64'hDEAD_BEEF_0123_4567);
    send_crc(16'h1234);
    repeat (5) tick();
    @(negedge sdc_clk);
    n_vec++;
    if ((we_cnt - we0) !== 0 || busy !== 1'b0 || ovr_err !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ignore: writes=%0d busy=%b ovr=%b, required 0 0 0", we_cnt - we0, busy, ovr_err);
    end
    n_vec++;
    if (dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL idle_state: got %0d, required 0", dbg_state);
    end
  endtask

  task automatic test_zero_block();
    int we0, d0, lat, dk;
    bit got;
    pulse_start();
    @(negedge sdc_clk);
    n_vec++;
    if (busy !== 1'b1 || dbg_state !== 3'd1) begin
      n_err++;
      $display("FAIL zero_start: busy=%b state=%0d, required busy=1 state=1", busy, dbg_state);
    end
    we0 = we_cnt;
    d0 = done_cnt;
    run_block(64'h0, 16'h0000, 1'b0, lat, got, dk);
    n_vec++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL zero_done_timeout: got no blk_done, required blk_done");
    end
    n_vec++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL zero_first_we_latency: got %0d, required 3", lat);
    end
    n_vec++;
    if (dk !== 53) begin
      n_err++;
      $display("FAIL zero_done_after_crc: got %0d cycles, required 53", dk);
    end
    n_vec++;
    if ({crc_ok, crc_err, ovr_err, busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL zero_flags: ok/err/ovr/busy=%b, required 1000", {crc_ok, crc_err, ovr_err, busy});
    end
    n_vec++;
    if (crc_calc !== 16'h0000) begin
      n_err++;
      $display("FAIL zero_crc_calc: got %h, required 0000", crc_calc);
    end
    repeat (5) tick();
    n_vec++;
    if ((done_cnt - d0) !== 1) begin
      n_err++;
      $display("FAIL zero_done_count: got %0d, required 1", done_cnt - d0);
    end
    n_vec++;
    if ((we_cnt - we0) !== 64 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL zero_write_count: got %0d (pending %0d), required 64 (pending 0)",
               we_cnt - we0, exp_q.size());
    end
    n_vec++;
    if (dbg_state !== 3'd0 || crc_ok !== 1'b1) begin
      n_err++;
      $display("FAIL zero_after: state=%0d ok=%b, required state=0 ok=1", dbg_state, crc_ok);
    end
  endtask

  task automatic test_ones_ok();
    int lat, dk;
    bit got;
    pulse_start();
    run_block(ONES, 16'h7FA1, 1'b0, lat, got, dk);
    n_vec++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL ones_ok_timeout: got no blk_done, required blk_done");
    end
    n_vec++;
    if (crc_calc !== 16'h7FA1) begin
      n_err++;
      $display("FAIL ones_ok_crc_calc: got %h, required 7fa1", crc_calc);
    end
    n_vec++;
    if ({crc_ok, crc_err, ovr_err} !== 3'b100) begin
      n_err++;
      $display("FAIL ones_ok_flags: ok/err/ovr=%b, required 100", {crc_ok, crc_err, ovr_err});
    end
  endtask

  task automatic test_ones_bad_excess();
    int lat, dk, we0;
    bit got;
    pulse_start();
    @(negedge sdc_clk);
    n_vec++;
    if (crc_ok !== 1'b0) begin
      n_err++;
      $display("FAIL start_clears_ok: got %b, required 0", crc_ok);
    end
    we0 = we_cnt;
    run_block(ONES, 16'h7FA0, 1'b1, lat, got, dk);
    n_vec++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL ones_bad_timeout: got no blk_done, required blk_done");
    end
    n_vec++;
    if (crc_calc !== 16'h7FA1) begin
      n_err++;
      $display("FAIL ones_bad_crc_calc: got %h, required 7fa1", crc_calc);
    end
    n_vec++;
    if ({crc_ok, crc_err, ovr_err} !== 3'b011) begin
      n_err++;
      $display("FAIL ones_bad_flags: ok/err/ovr=%b, required 011", {crc_ok, crc_err, ovr_err});
    end
    n_vec++;
    if ((we_cnt - we0) !== 64) begin
      n_err++;
      $display("FAIL excess_word_written: got %0d writes, required 64", we_cnt - we0);
    end
  endtask

  task automatic test_overrun();
    int we0;
    pulse_start();
    @(negedge sdc_clk);
    n_vec++;
    if ({ovr_err, crc_err} !== 2'b00) begin
      n_err++;
      $display("FAIL start_clears_ovr_err: ovr/err=%b, required 00", {ovr_err, crc_err});
    end
    we0 = we_cnt;
    exp_q.push_back({6'd0, 64'h1111_2222_3333_4444});
    exp_q.push_back({6'd1, 64'h5555_6666_7777_8888});
    send_word(64'h1111_2222_3333_4444);
    repeat (9) tick();
    send_word(64'h5555_6666_7777_8888);
    repeat (9) tick();
    send_word(64'h9999_AAAA_BBBB_CCCC);
    @(negedge sdc_clk);
    n_vec++;
    if (ovr_err !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_flag: got %b, required 1", ovr_err);
    end
    repeat (100) tick();
    n_vec++;
    if ((we_cnt - we0) !== 2 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL overrun_writes: got %0d (pending %0d), required 2 (pending 0)", we_cnt - we0, exp_q.size());
    end
    n_vec++;
    if ({ovr_err, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL overrun_sticky: ovr/busy=%b, required 11", {ovr_err, busy});
    end
  endtask

  task automatic test_abort();
    int we0, lat, dk;
    bit got;
    logic [ADDR_W-1:0] a;
    pulse_start();
    we0 = we_cnt;
    for (int i = 0; i < 20; i++) begin
      a = i[ADDR_W-1:0];
      exp_q.push_back({a, ONES});
      send_word(ONES);
      if (i < 19) repeat (65) tick();
    end
    repeat (29) tick();
    @(negedge sdc_clk);
    n_vec++;
    if (dbg_state !== 3'd3 || crc_calc === 16'h0000) begin
      n_err++;
      $display("FAIL abort_precondition: state=%0d crc=%h, required state=3 crc nonzero", dbg_state, crc_calc);
    end
    tick();
    pulse_start();
    @(negedge sdc_clk);
    n_vec++;
    if (crc_calc !== 16'h0000 || dbg_state !== 3'd1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_clear: crc=%h state=%0d busy=%b, required 0000 1 1", crc_calc, dbg_state, busy);
    end
    repeat (70) tick();
    n_vec++;
    if ((we_cnt - we0) !== 20) begin
      n_err++;
      $display("FAIL abort_writes: got %0d, required 20", we_cnt - we0);
    end
    run_block(ONES, 16'h7FA1, 1'b0, lat, got, dk);
    n_vec++;
    if (got !== 1'b1 || {crc_ok, crc_err, ovr_err} !== 3'b100) begin
      n_err++;
      $display("FAIL abort_clean_block: done=%b ok/err/ovr=%b, required 1 100", got, {crc_ok, crc_err, ovr_err});
    end
  endtask

  task automatic test_reset_mid();
    int we0;
    pulse_start();
    exp_q.push_back({6'd0, 64'hA5A5_5A5A_0F0F_F0F0});
    send_word(64'hA5A5_5A5A_0F0F_F0F0);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge sdc_clk);
    n_vec++;
    if ({bram_we, busy, blk_done, crc_ok, crc_err, ovr_err} !== 6'b0 ||
        {bram_addr, bram_din, crc_calc} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: we/busy/done/ok/err/ovr=%b din=%h crc=%h, required all 0",
               {bram_we, busy, blk_done, crc_ok, crc_err, ovr_err}, bram_din, crc_calc);
    end
    n_vec++;
    if (dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid_state: got %0d, required 0", dbg_state);
    end
    we0 = we_cnt;
    tick();
    send_word(64'h1234_5678_9ABC_DEF0);
    repeat (10) tick();
    @(negedge sdc_clk);
    n_vec++;
    if ((we_cnt - we0) !== 0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid_ignore: writes=%0d busy=%b state=%0d, required 0 0 0", we_cnt - we0, busy, dbg_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ignore_idle();
    test_zero_block();
    test_ones_ok();
    test_ones_bad_excess();
    test_overrun();
    test_abort();
    test_reset_mid();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
